// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter and the memory stage that sizes its addresses.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH  = 1024;
    localparam int unsigned DMEM_ADDR_W = $clog2(DMEM_DEPTH);
    localparam logic [63:0] DMEM_BYTES  = 64'(DMEM_DEPTH) * 64'd8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports and the memory-array port of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              c_req, c_we, c_gnt, c_rsp_valid, c_err;
    logic [63:0]       c_addr, c_wdata, c_rdata;
    logic              l_req, l_we, l_gnt, l_rsp_valid, l_err;
    logic [63:0]       l_addr, l_wdata, l_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata, mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_gnt, c_rsp_valid, c_rdata, c_err,
        output l_gnt, l_rsp_valid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_gnt, c_rsp_valid, c_rdata, c_err,
        input  l_gnt, l_rsp_valid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-port priority picker: C wins ties unless the starvation flag hands the slot to L.
module dmem_rr_pick (
    input  logic c_req,
    input  logic l_req,
    input  logic starve,
    output logic pick_c,
    output logic pick_l
);

    always_comb begin
        pick_l = l_req && (starve || !c_req);
        pick_c = c_req && !pick_l;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the memory stage (C) and the loader (L).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = DMEM_DEPTH,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [63:0] BYTES = 64'(DEPTH) * 64'd8;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, we_q, err_q;
    logic [63:0]      addr_q, wdata_q, c_rdata_q, l_rdata_q;
    logic             pick_c, pick_l, gnt_c, gnt_l, starve, legal, mem_go, resp;
    logic [63:0]      rsp_data;

    assign starve = (cnt_q == CNT_W'(MAX_WAIT));

    dmem_rr_pick u_pick (
        .c_req  (bus.c_req),
        .l_req  (bus.l_req),
        .starve (starve),
        .pick_c (pick_c),
        .pick_l (pick_l)
    );

    // Any upper address bit set fails the full 64-bit compare, so no aliasing.
    assign legal = (addr_q < BYTES) && (addr_q[2:0] == 3'b000);

    always_comb begin
        gnt_c    = (state_q == ST_IDLE) && pick_c;
        gnt_l    = (state_q == ST_IDLE) && pick_l;
        mem_go   = (state_q == ST_ACCESS) && legal;
        resp     = (state_q == ST_RESP);
        rsp_data = (!we_q && !err_q) ? bus.mem_rdata : 64'd0;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (gnt_c || gnt_l) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (gnt_l) begin
            cnt_d = '0;
        end else if (gnt_c && bus.l_req && !starve) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= PORT_C;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt_c || gnt_l) begin
                owner_q <= gnt_l ? PORT_L : PORT_C;
                we_q    <= gnt_l ? bus.l_we    : bus.c_we;
                addr_q  <= gnt_l ? bus.l_addr  : bus.c_addr;
                wdata_q <= gnt_l ? bus.l_wdata : bus.c_wdata;
            end
            if (state_q == ST_ACCESS) err_q <= !legal;
            if (resp && owner_q == PORT_C) c_rdata_q <= rsp_data;
            if (resp && owner_q == PORT_L) l_rdata_q <= rsp_data;
        end
    end

    // Grants are combinational from req, so mask them while reset is held.
    always_comb begin
        bus.c_gnt       = gnt_c && reset;
        bus.l_gnt       = gnt_l && reset;
        bus.c_rsp_valid = resp && (owner_q == PORT_C);
        bus.l_rsp_valid = resp && (owner_q == PORT_L);
        bus.c_err       = bus.c_rsp_valid && err_q;
        bus.l_err       = bus.l_rsp_valid && err_q;
        bus.c_rdata     = bus.c_rsp_valid ? rsp_data : c_rdata_q;
        bus.l_rdata     = bus.l_rsp_valid ? rsp_data : l_rdata_q;
        bus.mem_en      = mem_go;
        bus.mem_we      = mem_go && we_q;
        bus.mem_addr    = mem_go ? addr_q[ADDR_W+2:3] : '0;
        bus.mem_wdata   = mem_go ? wdata_q : 64'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x64 synchronous-read memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mem_en_cnt = 0;
    int   overlap_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(10)) bus ();

    dmem_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] mem_model [1024];
    logic [63:0] rd_q;

    always_ff @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= mem_model[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    always @(posedge clk) if (bus.mem_en) mem_en_cnt <= mem_en_cnt + 1;
    always @(negedge clk) begin
        if ((bus.c_gnt && bus.l_gnt) || (bus.c_rsp_valid && bus.l_rsp_valid))
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit port_l, input bit req, input bit we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (port_l) begin
            bus.l_req = req; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
        end else begin
            bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
        end
    endtask

    // Full transaction on one port; expects gnt within a bound and rsp exactly 2 cycles later.
    task automatic do_access(input string tag, input bit port_l, input bit we,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] exp_rdata, input bit exp_err);
        int waited = 0;
        drive(port_l, 1'b1, we, addr, wdata);
        #1;
        while (!(port_l ? bus.l_gnt : bus.c_gnt) && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check_eq({tag, " gnt"}, 64'(port_l ? bus.l_gnt : bus.c_gnt), 64'd1);
        if (waited < 20) begin
            @(negedge clk); #1;
            check_eq({tag, " rsp early"}, 64'(port_l ? bus.l_rsp_valid : bus.c_rsp_valid), 64'd0);
            @(negedge clk); #1;
            check_eq({tag, " rsp"}, 64'(port_l ? bus.l_rsp_valid : bus.c_rsp_valid), 64'd1);
            check_eq({tag, " rdata"}, port_l ? bus.l_rdata : bus.c_rdata, exp_rdata);
            check_eq({tag, " err"}, 64'(port_l ? bus.l_err : bus.c_err), 64'(exp_err));
        end
        drive(port_l, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " gnt"}, {62'd0, bus.c_gnt, bus.l_gnt}, 64'd0);
        check_eq({tag, " rsp"}, {62'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 64'd0);
        check_eq({tag, " err"}, {62'd0, bus.c_err, bus.l_err}, 64'd0);
        check_eq({tag, " c_rdata"}, bus.c_rdata, 64'd0);
        check_eq({tag, " l_rdata"}, bus.l_rdata, 64'd0);
        check_eq({tag, " mem ctl"}, {62'd0, bus.mem_en, bus.mem_we}, 64'd0);
        check_eq({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check_eq({tag, " mem_wdata"}, bus.mem_wdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int en_before;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        #1 check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Write then read back on C.
        do_access("t1 wr", 1'b0, 1'b1, 64'h10, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b0);
        do_access("t1 rd", 1'b0, 1'b0, 64'h10, 64'd0, 64'hDEADBEEFDEADBEEF, 1'b0);

        // Simultaneous requests: C first, then L.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
        #1 check_eq("t2 c first", {62'd0, bus.c_gnt, bus.l_gnt}, 64'b10);
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t2 c rsp", {62'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 64'b10);
        check_eq("t2 c rdata", bus.c_rdata, 64'hDEADBEEFDEADBEEF);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk); #1;
        check_eq("t2 l next", {62'd0, bus.c_gnt, bus.l_gnt}, 64'b01);
        @(negedge clk);
        @(negedge clk); #1;
        check_eq("t2 l rsp", {62'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 64'b01);
        check_eq("t2 l rdata", bus.l_rdata, 64'hDEADBEEFDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

        // Starvation: four C grants, then L, then C again.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'h10, 64'd0);
        for (int g = 0; g < 6; g++) begin
            #1 check_eq($sformatf("t3 grant %0d", g), {62'd0, bus.c_gnt, bus.l_gnt},
                        (g == 4) ? 64'b01 : 64'b10);
            @(negedge clk);
            @(negedge clk);
            if (g == 4) drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
            if (g == 5) drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
            @(negedge clk);
        end

        // Range and alignment errors never touch memory.
        do_access("t4 wr top", 1'b1, 1'b1, 64'h1FF8, 64'h5555555555555555, 64'd0, 1'b0);
        en_before = mem_en_cnt;
        do_access("t4 0x2000", 1'b1, 1'b0, 64'h2000, 64'd0, 64'd0, 1'b1);
        do_access("t4 0x0004", 1'b1, 1'b0, 64'h0004, 64'd0, 64'd0, 1'b1);
        do_access("t4 upper", 1'b1, 1'b0, 64'h0000_0100_0000_0010, 64'd0, 64'd0, 1'b1);
        check_eq("t4 mem_en quiet", 64'(mem_en_cnt - en_before), 64'd0);
        do_access("t4 rd top", 1'b1, 1'b0, 64'h1FF8, 64'd0, 64'h5555555555555555, 1'b0);
        do_access("t4 rd 0x10", 1'b0, 1'b0, 64'h10, 64'd0, 64'hDEADBEEFDEADBEEF, 1'b0);

        // Asynchronous reset in the middle of an access.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
        #1 check_eq("t5 gnt", 64'(bus.c_gnt), 64'd1);
        @(negedge clk); #1;
        check_eq("t5 mem_en", 64'(bus.mem_en), 64'd1);
        #1 reset = 1'b0;
        #1 check_idle_outputs("t5 in reset");
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        #1 check_eq("t5 no rsp", {62'd0, bus.c_rsp_valid, bus.l_rsp_valid}, 64'd0);
        reset = 1'b1;
        do_access("t5 after", 1'b0, 1'b0, 64'h10, 64'd0, 64'hDEADBEEFDEADBEEF, 1'b0);

        // L write then C read; L's held rdata is the write response (zero).
        do_access("t6 l wr", 1'b1, 1'b1, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'd0, 1'b0);
        do_access("t6 c rd", 1'b0, 1'b0, 64'h0, 64'd0, 64'hAAAAAAAAAAAAAAAA, 1'b0);
        check_eq("t6 l_rdata held", bus.l_rdata, 64'd0);
        @(negedge clk); #1;
        check_eq("t6 c_rdata held", bus.c_rdata, 64'hAAAAAAAAAAAAAAAA);

        check_eq("never both", 64'(overlap_cnt), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
